// File: rtl/demux_1to2_stream.sv
// ---------------------------------------------------------------------------
// demux_1to2_stream
//
// Registered 1-to-2 stream demultiplexer. One valid/ready input stream is
// steered packet-by-packet to output A or output B. The route is taken from
// s_sel on the first beat of a packet and held until the beat carrying
// s_last is accepted. Each output has a one-entry register stage and a
// wrapping completed-packet counter.
//
// Ports:
//   clk, rst                 - rising-edge clock, async active-high reset
//   s_data/s_last/s_sel      - input beat, last flag, route (first beat only)
//   s_valid/s_ready          - input handshake
//   a_data/a_last/a_valid    - output A beat, a_ready is its backpressure
//   b_data/b_last/b_valid    - output B beat, b_ready is its backpressure
//   a_pkt_cnt/b_pkt_cnt      - packets completed on A / B (wrap silently)
// ---------------------------------------------------------------------------
module demux_1to2_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  input  logic                 s_sel,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     a_data,
  output logic                 a_last,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     b_data,
  output logic                 b_last,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WIDTH-1:0] a_pkt_cnt,
  output logic [CNT_WIDTH-1:0] b_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t               state_q, state_d;

  logic                 a_valid_q, a_valid_d;
  logic [WIDTH-1:0]     a_data_q,  a_data_d;
  logic                 a_last_q,  a_last_d;
  logic                 b_valid_q, b_valid_d;
  logic [WIDTH-1:0]     b_data_q,  b_data_d;
  logic                 b_last_q,  b_last_d;
  logic [CNT_WIDTH-1:0] a_cnt_q,   a_cnt_d;
  logic [CNT_WIDTH-1:0] b_cnt_q,   b_cnt_d;

  logic                 dst_b;
  logic                 accept;

  // Destination: follows s_sel only between packets; once a packet has
  // started the locked side wins and s_sel is ignored.
  always_comb begin
    dst_b = s_sel;
    case (state_q)
      LOCK_A:  dst_b = 1'b0;
      LOCK_B:  dst_b = 1'b1;
      default: dst_b = s_sel;
    endcase
  end

  // Ready looks only at the destination register, so a stalled consumer on
  // the other side never blocks this packet.
  assign s_ready = dst_b ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_last_d  = a_last_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_last_d  = b_last_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;

    if (accept) begin
      if (s_last) begin
        state_d = IDLE;
      end else begin
        state_d = dst_b ? LOCK_B : LOCK_A;
      end
    end

    // A load wins over a drain in the same cycle: the new beat replaces the
    // one leaving, so valid stays high.
    if (accept && !dst_b) begin
      a_valid_d = 1'b1;
      a_data_d  = s_data;
      a_last_d  = s_last;
    end else if (a_ready) begin
      a_valid_d = 1'b0;
    end

    if (accept && dst_b) begin
      b_valid_d = 1'b1;
      b_data_d  = s_data;
      b_last_d  = s_last;
    end else if (b_ready) begin
      b_valid_d = 1'b0;
    end

    // Counters look at the beat leaving the register, independent of any
    // beat being loaded behind it.
    if (a_valid_q && a_ready && a_last_q) begin
      a_cnt_d = a_cnt_q + 1'b1;
    end
    if (b_valid_q && b_ready && b_last_q) begin
      b_cnt_d = b_cnt_q + 1'b1;
    end
  end

  // Route FSM, output registers and counters share one register block; a
  // reset drops the route lock and any held beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_last_q  <= a_last_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_last_q  <= b_last_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign a_valid   = a_valid_q;
  assign a_data    = a_data_q;
  assign a_last    = a_last_q;
  assign b_valid   = b_valid_q;
  assign b_data    = b_data_q;
  assign b_last    = b_last_q;
  assign a_pkt_cnt = a_cnt_q;
  assign b_pkt_cnt = b_cnt_q;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1to2_stream
//
// Bench for demux_1to2_stream. The counters are instantiated narrow so that
// wrap-around is reached quickly. Directed sequences with literal values come
// first, followed by a randomized run; a per-cycle compare process tracks
// the expected outputs with a transaction-level model throughout.
// ---------------------------------------------------------------------------
module tb_demux_1to2_stream;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 s_sel;
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     a_data;
  logic                 a_last;
  logic                 a_valid;
  logic                 a_ready;
  logic [WIDTH-1:0]     b_data;
  logic                 b_last;
  logic                 b_valid;
  logic                 b_ready;
  logic [CNT_WIDTH-1:0] a_pkt_cnt;
  logic [CNT_WIDTH-1:0] b_pkt_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  bit run_cmp       = 1'b1;

  demux_1to2_stream #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_sel     (s_sel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .a_pkt_cnt (a_pkt_cnt),
    .b_pkt_cnt (b_pkt_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic l, input logic sel);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    s_sel   = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each output is a slot holding at most one beat, the
  // route is the side a packet in flight belongs to (-1 between packets),
  // and each counter is the number of last beats handed to that consumer.
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
  } slot_t;

  slot_t m_slot[2];
  int    m_cnt[2];
  int    m_route;

  task automatic modelReset();
    for (int o = 0; o < 2; o++) begin
      m_slot[o].v = 1'b0;
      m_slot[o].d = '0;
      m_slot[o].l = 1'b0;
      m_cnt[o]    = 0;
    end
    m_route = -1;
  endtask

  // Compare, then advance the model with the inputs that the next rising
  // edge will sample (inputs only change just after a rising edge).
  initial begin
    modelReset();
    forever begin
      int   dst;
      logic rdy[2];
      logic exp_ready;
      logic acc;
      @(negedge clk);
      if (run_cmp) begin
        if (rst) modelReset();
        rdy[0]    = a_ready;
        rdy[1]    = b_ready;
        dst       = (m_route < 0) ? int'(s_sel) : m_route;
        exp_ready = !m_slot[dst].v || rdy[dst];
        checkOutput("cyc s_ready",   s_ready,   exp_ready);
        checkOutput("cyc a_valid",   a_valid,   m_slot[0].v);
        checkOutput("cyc a_data",    a_data,    m_slot[0].d);
        checkOutput("cyc a_last",    a_last,    m_slot[0].l);
        checkOutput("cyc b_valid",   b_valid,   m_slot[1].v);
        checkOutput("cyc b_data",    b_data,    m_slot[1].d);
        checkOutput("cyc b_last",    b_last,    m_slot[1].l);
        checkOutput("cyc a_pkt_cnt", a_pkt_cnt, m_cnt[0]);
        checkOutput("cyc b_pkt_cnt", b_pkt_cnt, m_cnt[1]);
        if (!rst) begin
          acc = s_valid && exp_ready;
          for (int o = 0; o < 2; o++) begin
            if (m_slot[o].v && rdy[o] && m_slot[o].l) begin
              m_cnt[o] = (m_cnt[o] + 1) % (1 << CNT_WIDTH);
            end
            if (acc && dst == o) begin
              m_slot[o].v = 1'b1;
              m_slot[o].d = s_data;
              m_slot[o].l = s_last;
            end else if (rdy[o]) begin
              m_slot[o].v = 1'b0;
            end
          end
          if (acc) m_route = s_last ? -1 : dst;
        end
      end
    end
  end

  initial begin
    bit held;
    rst     = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset a_valid",   a_valid,   0);
    checkOutput("reset b_valid",   b_valid,   0);
    checkOutput("reset a_data",    a_data,    0);
    checkOutput("reset a_pkt_cnt", a_pkt_cnt, 0);
    checkOutput("reset b_pkt_cnt", b_pkt_cnt, 0);
    rst = 1'b0;

    // Single-beat packets, one to each side.
    tick();
    applyStimulus(1'b1, 8'h08, 1'b1, 1'b0);
    #1 checkOutput("single s_ready", s_ready, 1);
    tick();
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b1);
    #1;
    checkOutput("single a_valid", a_valid, 1);
    checkOutput("single a_data",  a_data,  8'h08);
    checkOutput("single b_valid0", b_valid, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("single a_valid off", a_valid, 0);
    checkOutput("single b_valid",     b_valid, 1);
    checkOutput("single b_data",      b_data,  8'h10);
    checkOutput("single a_pkt_cnt",   a_pkt_cnt, 1);
    tick();
    checkOutput("single b_valid off", b_valid, 0);
    checkOutput("single b_pkt_cnt",   b_pkt_cnt, 1);

    // Route lock: sel toggles after the first beat but must be ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WIDTH'(i + 1), i == 3, i[0]);
      #1;
      if (i > 0) begin
        checkOutput("lock a_data",  a_data,  i);
        checkOutput("lock a_last",  a_last,  0);
        checkOutput("lock b_valid", b_valid, 0);
      end
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("lock a_data last", a_data, 8'h04);
    checkOutput("lock a_last last", a_last, 1);
    tick();
    checkOutput("lock a_pkt_cnt", a_pkt_cnt, 2);
    // Back in IDLE: a fresh packet with sel = 1 must go to B.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("idle b_valid", b_valid, 1);
    checkOutput("idle b_data",  b_data,  8'h55);
    checkOutput("idle a_valid", a_valid, 0);
    tick();

    // Backpressure on A with a two-beat packet.
    a_ready = 1'b0;
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    #1 checkOutput("bp s_ready empty", s_ready, 1);
    tick();
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b1);
    #1;
    checkOutput("bp a_data held", a_data,  8'h21);
    checkOutput("bp s_ready low", s_ready, 0);
    tick();
    checkOutput("bp a_data still", a_data,  8'h21);
    checkOutput("bp s_ready still", s_ready, 0);
    a_ready = 1'b1;
    #1 checkOutput("bp s_ready release", s_ready, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("bp a_data second", a_data, 8'h22);
    checkOutput("bp a_last second", a_last, 1);
    tick();
    checkOutput("bp a_valid off",  a_valid,   0);
    checkOutput("bp a_pkt_cnt",    a_pkt_cnt, 3);

    // Independence: B stalls with a beat held while A keeps streaming.
    b_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, WIDTH'(8'h41 + i), i == 2, 1'b0);
      #1;
      checkOutput("indep s_ready", s_ready, 1);
      checkOutput("indep b_data",  b_data,  8'h3C);
      checkOutput("indep b_valid", b_valid, 1);
      if (i > 0) checkOutput("indep a_data", a_data, 8'h41 + i - 1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("indep a_data last", a_data, 8'h43);
    checkOutput("indep b_data end",  b_data, 8'h3C);
    b_ready = 1'b1;
    tick();
    tick();
    checkOutput("indep a_pkt_cnt wrap", a_pkt_cnt, 0);
    checkOutput("indep b_pkt_cnt",      b_pkt_cnt, 3);

    // Reset in the middle of a four-beat packet to B.
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("midrst a_valid", a_valid,   0);
    checkOutput("midrst b_valid", b_valid,   0);
    checkOutput("midrst a_cnt",   a_pkt_cnt, 0);
    checkOutput("midrst b_cnt",   b_pkt_cnt, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("postrst a_valid", a_valid, 1);
    checkOutput("postrst a_data",  a_data,  8'h77);
    checkOutput("postrst b_valid", b_valid, 0);
    tick();

    // Counter wrap: five single-beat packets to A after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, WIDTH'(8'h80 + i), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("wrap a_pkt_cnt", a_pkt_cnt, 1);
    checkOutput("wrap b_pkt_cnt", b_pkt_cnt, 0);

    // Randomized traffic; the producer holds a beat until it is taken.
    held = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (c == 1000) begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        held = 1'b0;
        tick();
        rst = 1'b0;
      end
      a_ready = ($urandom_range(0, 9) < 7);
      b_ready = ($urandom_range(0, 9) < 6);
      if (!held) begin
        applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom),
                      $urandom_range(0, 2) == 0, 1'($urandom));
      end
      #1 held = s_valid && !s_ready;
    end
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
